score_digit_renderer: RTL
=========================

Name: score_digit_renderer

Overview:
- Keeps the 4-digit BCD game score and turns VGA beam coordinates into a 1-bit "score pixel on" signal for the pixel mux.
- Drives the 4-bit digit address of the registered glyph ROM (font_rom) and consumes its 32-bit glyph word one cycle later.
- The pipeline is aligned to that ROM's 1-cycle latency.
- Sits between the game FSM (score events), the VGA counter (hcount/vcount) and the VGA colour mux.

Parameters:
- NUM_DIGITS, 4, number of BCD digits displayed; supported range 1-4.
- X0, 560, screen x of the left edge of the leftmost digit (pixels, 0-639).
- Y0, 16, screen y of the top edge of the digits.
- COL_SCALE, 2, screen pixels per glyph column; power of two.
- ROW_SCALE, 4, screen lines per glyph row; power of two.
- DIGIT_GAP, 4, blank pixels between adjacent digits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- score_inc  in  1  one-cycle pulse: add 1 to score
- score_clr  in  1  one-cycle pulse: score := 0
- hcount  in  11  VGA horizontal count; pixel x = hcount[10:1]
- vcount  in  10  VGA line count; pixel y = vcount
- font_addr  out  4  registered digit address to the glyph ROM
- font_data  in  32  glyph word from the glyph ROM, valid 1 cycle after font_addr
- pixel_on  out  1  registered: current pixel is a lit score pixel
- score_bcd  out  4*NUM_DIGITS  live score; digit 0 (ones) in bits [3:0]

Behaviour:
- Clock and reset: single clock clk. Synchronous, active-high reset. At reset:
  - score_bcd=0 and the display latch = 0.
  - font_addr=4'hF and pixel_on=0.
  - All pipeline valid/in-box flags = 0.
- Score counter (BCD, per digit 0-9, ripple carry):
  - score_clr has priority over score_inc when both are asserted.
  - An increment at all-9s saturates; there is no wrap.
  - Example carries: 0009->0010, 0999->1000.
- Display latch: score_bcd is copied into disp_bcd on the cycle hcount==0 && vcount==0. The rendered score changes only at frame start, so there is no tearing.
- Glyph format: 8 columns x 4 rows.
  - Row r = font_data[31-8r -: 8].
  - Bit 7 of each byte is the leftmost column.
  - Cell size on screen: 8*COL_SCALE wide x 4*ROW_SCALE tall.
- Slot geometry: slot s (0 = leftmost, shows digit NUM_DIGITS-1-s) spans x in [X0+s*(8*COL_SCALE+DIGIT_GAP), +8*COL_SCALE-1] and y in [Y0, Y0+4*ROW_SCALE-1].
  - Slot is found by constant comparisons. No dividers.
  - Column = (x - slot_x0) >> log2(COL_SCALE); row = (y - Y0) >> log2(ROW_SCALE).
- Pipeline (input sample at cycle N):
  - Stage 1 (N+1): register in_box, col[2:0], row[1:0]. font_addr = selected disp_bcd digit if in_box, else 4'hF (the ROM returns 0 for 4'hF).
  - Stage 2 (N+2): font_data is valid. Delay in_box, col and row by one cycle to match.
  - Stage 3 (N+3): pixel_on = in_box_d2 & font_data[31-8*row_d2-col_d2]. pixel_on is registered.
  - Total latency hcount/vcount -> pixel_on is 3 cycles. The VGA top delays its colour/blank signals by 3 cycles to match.
- Boundaries:
  - Gap pixels and pixels outside the box give pixel_on=0 and font_addr=4'hF.
  - A reset mid-frame blanks output from the next cycle on. Rendering resumes with disp_bcd=0 until the next frame start.
  - A score change during the frame-start cycle: the latch takes the pre-edge score_bcd value.

Optional Feature:
- Macro: SCORE_LZ_BLANK_EN.
- When defined: leading-zero suppression. Every zero digit to the left of the most significant non-zero digit is rendered blank (font_addr=4'hF, pixel_on=0). The ones digit is always shown, so score 0 shows a single "0".
- When undefined: all NUM_DIGITS digits are always rendered, including leading zeros.

Test Plan:
- Reset -> score_bcd=16'h0000, font_addr=4'hF, pixel_on=0 for all hcount/vcount.
- 10 score_inc pulses from 0 -> score_bcd=16'h0010. Preload 0999 plus 1 pulse -> 16'h1000. 9999 plus 1 pulse -> stays 16'h9999.
- score_inc and score_clr asserted in the same cycle at score 0042 -> 16'h0000 next cycle.
- Score 0001 latched at frame start, font_rom attached, vcount=16:
  - hcount=1244 (x=622, slot 3, col 1) -> font_addr=4'd1 at N+1 and pixel_on=1 at N+3 (byte 0x63).
  - hcount=1240 (x=620, col 0) -> pixel_on=0 at N+3.
- Score changed from 0001 to 0002 at vcount=100 -> rendered glyph stays '1' for the rest of the frame and becomes '2' after the next hcount=0, vcount=0.
- Score 0007 with SCORE_LZ_BLANK_EN defined, x in slot 0 (x=560..575, y=16..31) -> font_addr=4'hF, pixel_on=0. Without the macro -> font_addr=4'd0 there.

Source files
------------

// File: rtl/score_digit_renderer_if.sv
// Bundle between the score renderer, game FSM, VGA counter, glyph ROM and colour mux.
// The slave side is the renderer; the master side drives beam position, score events and glyph data.
interface score_digit_renderer_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  logic                    score_inc;
  logic                    score_clr;
  logic [10:0]             hcount;
  logic [9:0]              vcount;
  logic [3:0]              font_addr;
  logic [31:0]             font_data;
  logic                    pixel_on;
  logic [4*NUM_DIGITS-1:0] score_bcd;

  modport master (
    output score_inc, score_clr, hcount, vcount, font_data,
    input  font_addr, pixel_on, score_bcd
  );

  modport slave (
    input  score_inc, score_clr, hcount, vcount, font_data,
    output font_addr, pixel_on, score_bcd
  );
endinterface

// File: rtl/score_digit_renderer.sv
// BCD score counter and 3-stage score pixel renderer, aligned to a 1-cycle glyph ROM.
// Defining SCORE_LZ_BLANK_EN blanks zero digits left of the most significant non-zero digit.
module score_digit_renderer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned X0         = 560,
  parameter int unsigned Y0         = 16,
  parameter int unsigned COL_SCALE  = 2,
  parameter int unsigned ROW_SCALE  = 4,
  parameter int unsigned DIGIT_GAP  = 4
) (
  input logic                   clk,
  input logic                   reset,
  score_digit_renderer_if.slave bus
);
  localparam int unsigned W        = 4 * NUM_DIGITS;
  localparam int unsigned CellW    = 8 * COL_SCALE;
  localparam int unsigned CellH    = 4 * ROW_SCALE;
  localparam int unsigned Pitch    = CellW + DIGIT_GAP;
  localparam int unsigned ColShift = $clog2(COL_SCALE);
  localparam int unsigned RowShift = $clog2(ROW_SCALE);

  logic [W-1:0]          score_q, score_d, disp_q;
  logic                  all_nines, carry;
  logic [NUM_DIGITS-1:0] blank;
  logic                  lead;
  int unsigned           x, y, lo;
  logic                  in_y, hit;
  logic [2:0]            col_d;
  logic [1:0]            row_d;
  logic [3:0]            addr_d;

  logic [3:0]            font_addr_q;
  logic                  in_box_q, in_box_d2, pixel_on_q;
  logic [2:0]            col_q, col_d2;
  logic [1:0]            row_q, row_d2;

  // Ripple-carry BCD increment; saturates at all nines, clear wins over increment.
  always_comb begin
    score_d   = score_q;
    all_nines = 1'b1;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
    if (bus.score_clr) begin
      score_d = '0;
    end else if (bus.score_inc && !all_nines) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (score_q[4*i +: 4] == 4'd9) begin
            score_d[4*i +: 4] = 4'd0;
          end else begin
            score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    blank = '0;
    lead  = 1'b1;
`ifdef SCORE_LZ_BLANK_EN
    // The ones digit (index 0) is never blanked.
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      lead     = lead && (disp_q[4*i +: 4] == 4'd0);
      blank[i] = lead;
    end
`endif
  end

  // Slot decode by constant range compares; slot s shows digit NUM_DIGITS-1-s.
  always_comb begin
    x      = 32'(bus.hcount[10:1]);
    y      = 32'(bus.vcount);
    in_y   = (y >= Y0) && (y < Y0 + CellH);
    row_d  = 2'((y - Y0) >> RowShift);
    hit    = 1'b0;
    col_d  = '0;
    addr_d = 4'hF;
    lo     = 0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      lo = X0 + (NUM_DIGITS - 1 - d) * Pitch;
      if (in_y && !blank[d] && (x >= lo) && (x < lo + CellW)) begin
        hit    = 1'b1;
        col_d  = 3'((x - lo) >> ColShift);
        addr_d = disp_q[4*d +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q     <= '0;
      disp_q      <= '0;
      font_addr_q <= 4'hF;
      in_box_q    <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      in_box_d2   <= 1'b0;
      col_d2      <= '0;
      row_d2      <= '0;
      pixel_on_q  <= 1'b0;
    end else begin
      score_q <= score_d;
      if (bus.hcount == 11'd0 && bus.vcount == 10'd0) disp_q <= score_q;
      font_addr_q <= hit ? addr_d : 4'hF;
      in_box_q    <= hit;
      col_q       <= col_d;
      row_q       <= row_d;
      in_box_d2   <= in_box_q;
      col_d2      <= col_q;
      row_d2      <= row_q;
      // {row, col} equals 8*row + col, so this picks font_data[31 - 8*row - col].
      pixel_on_q  <= in_box_d2 & bus.font_data[5'd31 - {row_d2, col_d2}];
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.font_addr = font_addr_q;
  assign bus.pixel_on  = pixel_on_q;
endmodule
